// File: rtl/motion_cmd_arbiter_pkg.sv
// Shared types for the motion command arbiter: the five-line motor command
// bundle, the arbiter state encoding and the safe-handover command helper.
package motion_arb_pkg;

  typedef struct packed {
    logic count_reset;
    logic motor_l_reset;
    logic motor_l_direction;
    logic motor_r_reset;
    logic motor_r_direction;
  } motor_cmd_t;

  typedef enum logic {
    OWNED = 1'b0,
    GUARD = 1'b1
  } arb_state_t;

  // Value driven while reset is held: everything in reset, directions low.
  localparam motor_cmd_t RESET_CMD = '{
    count_reset:       1'b1,
    motor_l_reset:     1'b1,
    motor_l_direction: 1'b0,
    motor_r_reset:     1'b1,
    motor_r_direction: 1'b0
  };

  // Safe handover command: counter and both motors held in reset, directions
  // kept at their previous value so re-enable never sees a direction glitch.
  function automatic motor_cmd_t make_safe(motor_cmd_t prev);
    motor_cmd_t safe;
    safe               = prev;
    safe.count_reset   = 1'b1;
    safe.motor_l_reset = 1'b1;
    safe.motor_r_reset = 1'b1;
    return safe;
  endfunction

endpackage

// File: rtl/motion_cmd_arbiter_if.sv
// Bus between the motion sources (master side) and the arbiter (slave side):
// per-source requests and commands in, the selected registered command out.
interface motion_cmd_arbiter_if #(
  parameter int N_SRC = 3
);
  localparam int OWN_W = $clog2(N_SRC);

  logic [N_SRC-1:0] req;
  logic [N_SRC-1:0] src_count_reset;
  logic [N_SRC-1:0] src_motor_l_reset;
  logic [N_SRC-1:0] src_motor_l_direction;
  logic [N_SRC-1:0] src_motor_r_reset;
  logic [N_SRC-1:0] src_motor_r_direction;

  logic             count_reset;
  logic             motor_l_reset;
  logic             motor_l_direction;
  logic             motor_r_reset;
  logic             motor_r_direction;
  logic [OWN_W-1:0] owner;
  logic             handover;

  modport master (
    output req, src_count_reset, src_motor_l_reset, src_motor_l_direction,
           src_motor_r_reset, src_motor_r_direction,
    input  count_reset, motor_l_reset, motor_l_direction, motor_r_reset,
           motor_r_direction, owner, handover
  );

  modport slave (
    input  req, src_count_reset, src_motor_l_reset, src_motor_l_direction,
           src_motor_r_reset, src_motor_r_direction,
    output count_reset, motor_l_reset, motor_l_direction, motor_r_reset,
           motor_r_direction, owner, handover
  );
endinterface

// File: rtl/motion_cmd_arbiter_prio_select.sv
// Combinational winner selection: highest requesting index >= 1, else the
// default source 0. Build option MOTION_ARB_STICKY_EN makes a current owner
// i >= 1 keep ownership while its request stays high (non-preemptive).
module motion_prio_select #(
  parameter  int N_SRC = 3,
  localparam int OWN_W = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [OWN_W-1:0] owner,
  output logic [OWN_W-1:0] winner
);

  // req[0] is implied high, so only sources 1..N_SRC-1 are scanned.
  logic unused_inputs;
  assign unused_inputs = ^{req[0], owner};

  // Priority scan with optional stickiness for a live non-default owner.
  always_comb begin
    winner = '0;
    for (int i = 1; i < N_SRC; i++) begin
      if (req[i]) winner = OWN_W'(i);
    end
`ifdef MOTION_ARB_STICKY_EN
    if (owner != '0 && req[owner]) winner = owner;
`endif
  end

endmodule

// File: rtl/motion_cmd_arbiter.sv
// Motion command arbiter: picks which source drives the counter reset and
// motor reset/direction lines, inserting a GUARD_CYCLES-long safe window on
// every ownership change. All outputs are registered (1-cycle latency).
// Optional build macro: MOTION_ARB_STICKY_EN (non-preemptive ownership).
module motion_cmd_arbiter #(
  parameter  int N_SRC        = 3,
  parameter  int GUARD_CYCLES = 2,
  localparam int OWN_W        = $clog2(N_SRC)
) (
  input logic                 clk,
  input logic                 reset,
  motion_cmd_arbiter_if.slave bus
);
  import motion_arb_pkg::*;

  localparam logic [3:0] GUARD_LOAD = 4'(GUARD_CYCLES - 1);

  arb_state_t       state_q, state_d;
  logic [OWN_W-1:0] owner_q, owner_d;
  logic [3:0]       guard_cnt_q, guard_cnt_d;
  logic             handover_q, handover_d;
  motor_cmd_t       cmd_q, cmd_d;
  logic [OWN_W-1:0] winner;
  motor_cmd_t       src_cmd [N_SRC];

  // Gather each source's five command lines into one struct per source.
  generate
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
      assign src_cmd[gi] = '{
        count_reset:       bus.src_count_reset[gi],
        motor_l_reset:     bus.src_motor_l_reset[gi],
        motor_l_direction: bus.src_motor_l_direction[gi],
        motor_r_reset:     bus.src_motor_r_reset[gi],
        motor_r_direction: bus.src_motor_r_direction[gi]
      };
    end
  endgenerate

  motion_prio_select #(.N_SRC(N_SRC)) u_prio (
    .req    (bus.req),
    .owner  (owner_q),
    .winner (winner)
  );

  // Next-state: pass the owner's command, or enter/restart/leave the guard.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    guard_cnt_d = guard_cnt_q;
    handover_d  = handover_q;
    cmd_d       = cmd_q;
    if (winner != owner_q) begin
      // Any re-target, from OWNED or mid-GUARD, (re)starts a full window.
      state_d     = GUARD;
      owner_d     = winner;
      guard_cnt_d = GUARD_LOAD;
      handover_d  = 1'b1;
      cmd_d       = make_safe(cmd_q);
    end else if (state_q == GUARD) begin
      if (guard_cnt_q == 4'd0) begin
        state_d    = OWNED;
        handover_d = 1'b0;
        cmd_d      = src_cmd[owner_q];
      end else begin
        guard_cnt_d = guard_cnt_q - 4'd1;
        handover_d  = 1'b1;
        cmd_d       = make_safe(cmd_q);
      end
    end else begin
      handover_d = 1'b0;
      cmd_d      = src_cmd[owner_q];
    end
  end

  // State and output registers; reset forces source 0 with everything reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= OWNED;
      owner_q     <= '0;
      guard_cnt_q <= 4'd0;
      handover_q  <= 1'b0;
      cmd_q       <= RESET_CMD;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      guard_cnt_q <= guard_cnt_d;
      handover_q  <= handover_d;
      cmd_q       <= cmd_d;
    end
  end

  assign bus.count_reset       = cmd_q.count_reset;
  assign bus.motor_l_reset     = cmd_q.motor_l_reset;
  assign bus.motor_l_direction = cmd_q.motor_l_direction;
  assign bus.motor_r_reset     = cmd_q.motor_r_reset;
  assign bus.motor_r_direction = cmd_q.motor_r_direction;
  assign bus.owner             = owner_q;
  assign bus.handover          = handover_q;

endmodule

// File: tb/tb_motion_cmd_arbiter.sv
// Bench for motion_cmd_arbiter: directed steps followed by random traffic,
// every cycle compared against a reference model that tracks the owner and
// the number of safe cycles still to show after each ownership change.
module tb_motion_cmd_arbiter;
  localparam int N = 3;
  localparam int G = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  motion_cmd_arbiter_if #(.N_SRC(N)) bus ();

  motion_cmd_arbiter #(.N_SRC(N), .GUARD_CYCLES(G)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state
  int   m_owner = 0;
  int   m_safe_left = 0;
  logic e_cr, e_lr, e_ld, e_rr, e_rd, e_ho;

  function automatic int ref_winner(input logic [N-1:0] r, input int cur);
    int w = 0;
    for (int i = 1; i < N; i++) if (r[i]) w = i;
`ifdef MOTION_ARB_STICKY_EN
    if (cur != 0 && r[cur]) w = cur;
`endif
    return w;
  endfunction

  // Advance the model by one clock edge using the inputs sampled there.
  task automatic model_edge();
    int w;
    if (rst) begin
      m_owner = 0; m_safe_left = 0;
      e_cr = 1; e_lr = 1; e_ld = 0; e_rr = 1; e_rd = 0; e_ho = 0;
    end else begin
      w = ref_winner(bus.req, m_owner);
      if (w != m_owner) begin
        m_owner     = w;
        m_safe_left = G;
      end
      if (m_safe_left > 0) begin
        e_cr = 1; e_lr = 1; e_rr = 1; e_ho = 1;
        m_safe_left--;
      end else begin
        e_cr = bus.src_count_reset[m_owner];
        e_lr = bus.src_motor_l_reset[m_owner];
        e_ld = bus.src_motor_l_direction[m_owner];
        e_rr = bus.src_motor_r_reset[m_owner];
        e_rd = bus.src_motor_r_direction[m_owner];
        e_ho = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count_reset"}, {3'b0, bus.count_reset},       {3'b0, e_cr});
    chk({tag, ".l_reset"},     {3'b0, bus.motor_l_reset},     {3'b0, e_lr});
    chk({tag, ".l_dir"},       {3'b0, bus.motor_l_direction}, {3'b0, e_ld});
    chk({tag, ".r_reset"},     {3'b0, bus.motor_r_reset},     {3'b0, e_rr});
    chk({tag, ".r_dir"},       {3'b0, bus.motor_r_direction}, {3'b0, e_rd});
    chk({tag, ".owner"},       4'(bus.owner),                 4'(m_owner));
    chk({tag, ".handover"},    {3'b0, bus.handover},          {3'b0, e_ho});
    $display("cyc=%0d %s rst=%0b req=%b owner=%0d ho=%0b cmd=%b%b%b%b%b", cyc, tag, rst,
             bus.req, bus.owner, bus.handover, bus.count_reset, bus.motor_l_reset,
             bus.motor_l_direction, bus.motor_r_reset, bus.motor_r_direction);
  endtask

  // One clock: model follows the edge, outputs compared 1 time unit later.
  task automatic tick(input string tag);
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic ticks(input string tag, input int n);
    for (int k = 0; k < n; k++) tick(tag);
  endtask

  // Bit layout per source: {cr, lr, ld, rr, rd}
  task automatic set_src(input int s, input logic [4:0] c);
    bus.src_count_reset[s]       = c[4];
    bus.src_motor_l_reset[s]     = c[3];
    bus.src_motor_l_direction[s] = c[2];
    bus.src_motor_r_reset[s]     = c[1];
    bus.src_motor_r_direction[s] = c[0];
  endtask

  initial begin
    bus.req = '0;
    set_src(0, 5'b00100);   // src0: resets low, l_dir=1, r_dir=0
    set_src(1, 5'b00001);   // src1: r_dir=1
    set_src(2, 5'b10110);   // src2: count_reset=1, l_dir=1, r_reset=1
    rst = 1'b1;

    ticks("reset", 3);
    #1 rst = 1'b0;
    ticks("src0", 6);

    bus.req[1] = 1'b1;
    ticks("to_src1", 4);

    bus.req[2] = 1'b1;
    ticks("pre_src2", 4);
    bus.req[1] = 1'b0;
    ticks("rel_src1", 4);

    bus.req = '0;
    ticks("back0", 4);

    bus.req[1] = 1'b1;
    tick("restart_a");
    bus.req[2] = 1'b1;
    ticks("restart_b", 4);

    bus.req = 3'b100;
    ticks("own2", 3);
    bus.req = '0;
    tick("guard_to0");
    rst = 1'b1;
    tick("rst_mid_guard");
    rst = 1'b0;
    ticks("post_rst", 3);

    bus.req[1] = 1'b1;
    tick("pulse_on");
    bus.req[1] = 1'b0;
    ticks("pulse_off", 5);

    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 5) == 0) bus.req = N'($urandom);
      bus.src_count_reset       = N'($urandom);
      bus.src_motor_l_reset     = N'($urandom);
      bus.src_motor_l_direction = N'($urandom);
      bus.src_motor_r_reset     = N'($urandom);
      bus.src_motor_r_direction = N'($urandom);
      rst = ($urandom_range(0, 39) == 0);
      tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/motion_cmd_arbiter.md
Name: motion_cmd_arbiter

Overview:
Parametrised, registered arbiter that selects which of N_SRC motion sources drives the shared counter-reset and motor reset/direction lines. Source 0 is the default line-follow controller. Higher sources are manoeuvre units such as turns/crossing and station handling. On every ownership change the block inserts a guard window in which both motors and the counter are held in reset, so a new owner never inherits a running motor. It sits between the manoeuvre units and the motor/timebase blocks, replacing the fixed two-way selection.

Parameters:
N_SRC, 3, number of command sources (2..8); index 0 = default controller; higher index = higher priority
GUARD_CYCLES, 2, length in clk cycles of the safe handover window (1..15)
OWN_W, $clog2(N_SRC), width of owner index (derived, not overridden)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req  in  N_SRC  ownership request per source; req[0] ignored, source 0 implicitly always requests
src_count_reset  in  N_SRC  per-source counter reset command
src_motor_l_reset  in  N_SRC  per-source left motor reset
src_motor_l_direction  in  N_SRC  per-source left motor direction
src_motor_r_reset  in  N_SRC  per-source right motor reset
src_motor_r_direction  in  N_SRC  per-source right motor direction
count_reset  out  1  registered counter reset to timebase
motor_l_reset  out  1  registered left motor reset
motor_l_direction  out  1  registered left motor direction
motor_r_reset  out  1  registered right motor reset
motor_r_direction  out  1  registered right motor direction
owner  out  OWN_W  index of current owner
handover  out  1  high while in GUARD

Behaviour:
- Reset: already decided, one clock, reset is synchronous and active-high.
- While reset is high: state=OWNED, owner=0, guard_cnt=0, handover=0, count_reset=1, motor_l_reset=1, motor_r_reset=1, both directions=0.
- Winner (combinational): highest index i≥1 with req[i]=1, else 0.
- All outputs are registered. Latency is 1 cycle from a source command to the output pins.
- OWNED state:
  - If winner==owner: outputs <= src_*[owner] on every edge.
  - If winner!=owner: next edge sets state=GUARD, owner=winner, guard_cnt=GUARD_CYCLES-1, and loads the safe command.
- Safe command: count_reset=1, both motor resets=1, both directions hold their last value.
- GUARD state:
  - Outputs hold the safe command and handover=1.
  - If winner!=owner: owner=winner, guard_cnt reloaded to GUARD_CYCLES-1, remain in GUARD (restart on re-target).
  - Else if guard_cnt==0: state=OWNED, and outputs <= src_*[owner] on that edge.
  - Else: guard_cnt decrements.
- With a stable winner, the safe command is visible for exactly GUARD_CYCLES cycles. The new owner's command appears on the following cycle.
- Request drop: a request dropping to 0 is an ownership change like any other; fall-back to source 0 also takes a guard.
- Simultaneous requests: resolved by the winner rule. Equal-cycle rise and fall is evaluated on the sampled req vector only.
- Reset mid-GUARD: the block returns to the reset values immediately. No guard follows reset release; source 0 drives from the first post-reset edge.
- Directions are never forced during GUARD, which prevents direction glitches on re-enable.

Optional Feature:
MOTION_ARB_STICKY_EN
- Defined: non-preemptive. Once a source i≥1 owns (OWNED or GUARD), winner stays i while req[i]=1, even if a higher index requests. On release, normal priority picks the next owner.
- Undefined: fully preemptive priority as described above.
- Source 0 is always preemptable in both modes.

Decomposition:
- Package motion_arb_pkg:
  - typedef motor_cmd_t, a packed struct {count_reset, motor_l_reset, motor_l_direction, motor_r_reset, motor_r_direction}
  - state enum arb_state_t {OWNED, GUARD}
  - function make_safe(motor_cmd_t prev) returning the safe command
- Sub-module motion_prio_select: purely combinational winner selection, including the sticky logic under the macro. Inputs: req and current owner; output: winner.

Test Plan:
- Reset held 3 cycles, src0 drives l_reset=0, r_reset=0, dirs=1/0 -> during reset all resets=1 and dirs=0; 1 cycle after release outputs=src0, owner=0, handover=0.
- req[1] rises at cycle 10 (GUARD_CYCLES=2) -> handover=1 and safe cmd in cycles 11–12, dirs unchanged; cycle 13 outputs=src1, owner=1.
- Owner 1, req[2] rises -> preemption: guard of 2 cycles, then owner=2. With MOTION_ARB_STICKY_EN: owner stays 1 until req[1] drops, then guard, then owner=2.
- req[1] rises, then req[2] rises in the first guard cycle -> guard restarts, owner=2, total handover=3 cycles, src1 never reaches the outputs.
- Owner 2, reset asserted in the middle of GUARD -> the next edge shows the reset values, owner=0; after release src0 passes with no guard.
- req[1] toggles for 1 cycle -> two guard windows back-to-back-with-restart; the motor resets remain 1 throughout and no src1 command ever reaches the outputs.
